// File: rtl/serializador_8x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serializador_8x1                                           |
// | Description : Upstream sequencer for an 8:1 mux stage. Accepts an 8-bit  |
// |               word through a valid/ready handshake, holds it on the mux  |
// |               data bus (entrada) and steps the 3-bit mux select through  |
// |               all eight positions. Each position is held for DIV clocks. |
// |               Together with the mux it forms a parallel-to-serial        |
// |               converter.                                                 |
// |                                                                          |
// | Parameters  : DIV       clocks per serial bit, 1..256                    |
// |               MSB_FIRST 0: sel counts 0->7, 1: sel counts 7->0           |
// |                                                                          |
// | Ports       : clk        in   system clock, rising edge                  |
// |               rst_n      in   asynchronous active-low reset              |
// |               data_in    in   [7:0] word to serialize                    |
// |               load_valid in   data_in valid                              |
// |               load_ready out  block can accept a word (combinational)    |
// |               pause      in   (SERIALIZADOR_PAUSE_EN only) freeze shift  |
// |               entrada    out  [7:0] registered word to the mux inputs    |
// |               sel        out  [2:0] registered mux select                |
// |               bit_valid  out  mux output carries a valid serial bit      |
// |               busy       out  serialization in progress                  |
// |               done       out  one-cycle pulse after the last bit         |
// |                                                                          |
// | Options     : define SERIALIZADOR_PAUSE_EN to add the pause input.       |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module serializador_8x1 #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       load_valid,
  output logic       load_ready,
`ifdef SERIALIZADOR_PAUSE_EN
  input  logic       pause,
`endif
  output logic [7:0] entrada,
  output logic [2:0] sel,
  output logic       bit_valid,
  output logic       busy,
  output logic       done
);

  // Divider counter width: max(1, clog2(DIV)); DIV=256 still fits 0..255.
  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);

  // Scan direction endpoints.
  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  generate
    if ((DIV < 1) || (DIV > 256)) begin : g_div_check
      $error("serializador_8x1: DIV must be in 1..256");
    end
  endgenerate

  logic [1:0]       state_q,     state_d;
  logic [7:0]       entrada_q,   entrada_d;
  logic [2:0]       sel_q,       sel_d;
  logic [CNT_W-1:0] div_cnt_q,   div_cnt_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Pause request; tied off when the feature is not built in.
  logic pause_req;
`ifdef SERIALIZADOR_PAUSE_EN
  assign pause_req = pause;
`else
  assign pause_req = 1'b0;
`endif

  // Only meaningful while shifting; pause is ignored in IDLE and DONE.
  logic shift_hold;
  assign shift_hold = (state_q == ST_SHIFT) && pause_req;

  // Select step in the configured direction (3-bit wrap is never reached
  // because the end index terminates the scan first).
  logic [2:0] sel_next;
  assign sel_next = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);

  always_comb begin
    state_d   = state_q;
    entrada_d = entrada_q;
    sel_d     = sel_q;
    div_cnt_d = div_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // load_ready is 1 in IDLE, so load_valid alone completes the handshake.
        if (load_valid) begin
          entrada_d = data_in;
          sel_d     = START_IDX;
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!shift_hold) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (sel_q == END_IDX) begin
              // Leave sel parked at the start index for the next word.
              sel_d   = START_IDX;
              state_d = ST_DONE;
            end else begin
              sel_d = sel_next;
            end
          end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the registered sel/entrada they describe.
  always_comb begin
    busy_d      = (state_d == ST_SHIFT);
    bit_valid_d = (state_d == ST_SHIFT) && !shift_hold;
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      entrada_q   <= 8'd0;
      sel_q       <= 3'd0;
      div_cnt_q   <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      entrada_q   <= entrada_d;
      sel_q       <= sel_d;
      div_cnt_q   <= div_cnt_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Combinational so it reads 1 while reset holds the FSM in IDLE.
  assign load_ready = (state_q == ST_IDLE);

  assign entrada   = entrada_q;
  assign sel       = sel_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serializador_8x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serializador_8x1                                        |
// | Description : Directed self-checking bench for serializador_8x1 using    |
// |               three instances: DIV=1/LSB-first, DIV=2/LSB-first and      |
// |               DIV=3/MSB-first. Pause scenario built with                 |
// |               SERIALIZADOR_PAUSE_EN.                                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_serializador_8x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       lv1, lv2, lv3;
`ifdef SERIALIZADOR_PAUSE_EN
  logic       pause;
`endif

  logic       lr1, lr2, lr3;
  logic [7:0] ent1, ent2, ent3;
  logic [2:0] sel1, sel2, sel3;
  logic       bv1, bv2, bv3;
  logic       busy1, busy2, busy3;
  logic       done1, done2, done3;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  serializador_8x1 #(.DIV(1), .MSB_FIRST(1'b0)) u_div1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(lv1), .load_ready(lr1),
`ifdef SERIALIZADOR_PAUSE_EN
    .pause(pause),
`endif
    .entrada(ent1), .sel(sel1), .bit_valid(bv1), .busy(busy1), .done(done1)
  );

  serializador_8x1 #(.DIV(2), .MSB_FIRST(1'b0)) u_div2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(lv2), .load_ready(lr2),
`ifdef SERIALIZADOR_PAUSE_EN
    .pause(1'b0),
`endif
    .entrada(ent2), .sel(sel2), .bit_valid(bv2), .busy(busy2), .done(done2)
  );

  serializador_8x1 #(.DIV(3), .MSB_FIRST(1'b1)) u_div3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(lv3), .load_ready(lr3),
`ifdef SERIALIZADOR_PAUSE_EN
    .pause(1'b0),
`endif
    .entrada(ent3), .sel(sel3), .bit_valid(bv3), .busy(busy3), .done(done3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data_in = 8'h00; lv1 = 1'b0; lv2 = 1'b0; lv3 = 1'b0;
`ifdef SERIALIZADOR_PAUSE_EN
    pause = 1'b0;
`endif
    #1;
    n_checks++;
    if (lr1 !== 1'b1) $display("FAIL reset_load_ready: got %b expected 1", lr1);
    else n_pass++;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_checks++;
      if ({lr1, sel1, ent1, bv1, busy1, done1} !== {1'b1, 3'd0, 8'd0, 3'b000})
        $display("FAIL reset_idle cycle %0d: got %b expected %b", i,
                 {lr1, sel1, ent1, bv1, busy1, done1}, {1'b1, 3'd0, 8'd0, 3'b000});
      else n_pass++;
    end
    n_checks++;
    if ({lr3, sel3, ent3, bv3, busy3, done3} !== {1'b1, 3'd0, 8'd0, 3'b000})
      $display("FAIL reset_idle_msb: got %b expected %b",
               {lr3, sel3, ent3, bv3, busy3, done3}, {1'b1, 3'd0, 8'd0, 3'b000});
    else n_pass++;
  endtask

  task automatic test_div1_lsb;
    logic exp_seq [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    data_in = 8'hA5; lv1 = 1'b1;
    tick;
    lv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sel1 !== 3'(i)) $display("FAIL div1_sel step %0d: got %0d expected %0d", i, sel1, i);
      else n_pass++;
      n_checks++;
      if ({bv1, busy1, done1, lr1} !== 4'b1100)
        $display("FAIL div1_flags step %0d: got %b expected 1100", i, {bv1, busy1, done1, lr1});
      else n_pass++;
      n_checks++;
      if (ent1[sel1] !== exp_seq[i])
        $display("FAIL div1_bit step %0d: got %b expected %b", i, ent1[sel1], exp_seq[i]);
      else n_pass++;
      if (i < 7) tick;
    end
    tick;
    n_checks++;
    if ({done1, busy1, bv1, lr1, sel1} !== {4'b1000, 3'd0})
      $display("FAIL div1_done: got %b expected %b", {done1, busy1, bv1, lr1, sel1}, {4'b1000, 3'd0});
    else n_pass++;
    tick;
    n_checks++;
    if ({done1, lr1, ent1} !== {2'b01, 8'hA5})
      $display("FAIL div1_idle_after: got %b expected %b", {done1, lr1, ent1}, {2'b01, 8'hA5});
    else n_pass++;
  endtask

  task automatic test_div3_msb;
    // Serial bits in emission order (sel 7 down to 0) of 8'h81.
    logic exp_seq [0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    data_in = 8'h81; lv3 = 1'b1;
    tick;
    lv3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (sel3 !== 3'(7 - k / 3))
        $display("FAIL div3_sel cycle %0d: got %0d expected %0d", k, sel3, 7 - k / 3);
      else n_pass++;
      n_checks++;
      if ({bv3, done3, ent3[sel3]} !== {2'b10, exp_seq[k / 3]})
        $display("FAIL div3_bit cycle %0d: got %b expected %b", k,
                 {bv3, done3, ent3[sel3]}, {2'b10, exp_seq[k / 3]});
      else n_pass++;
      if (k < 23) tick;
    end
    tick;
    n_checks++;
    if ({done3, busy3, bv3, sel3} !== {3'b100, 3'd7})
      $display("FAIL div3_done: got %b expected %b", {done3, busy3, bv3, sel3}, {3'b100, 3'd7});
    else n_pass++;
    tick;
    n_checks++;
    if ({done3, lr3} !== 2'b01)
      $display("FAIL div3_idle_after: got %b expected 01", {done3, lr3});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int   first  = -1;
    int   second = -1;
    logic prev;
    data_in = 8'h0F; lv1 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      prev = lr1;
      tick;
      if (prev && lv1) begin
        if (first < 0) begin
          first = cyc;
          n_checks++;
          if (ent1 !== 8'h0F) $display("FAIL b2b_first_word: got %h expected 0f", ent1);
          else n_pass++;
          data_in = 8'hF0;
        end else if (second < 0) begin
          second = cyc;
          n_checks++;
          if (ent1 !== 8'hF0) $display("FAIL b2b_second_word: got %h expected f0", ent1);
          else n_pass++;
        end
      end
    end
    lv1 = 1'b0;
    n_checks++;
    if (first !== 1) $display("FAIL b2b_first_accept: got cycle %0d expected 1", first);
    else n_pass++;
    n_checks++;
    if (second - first !== 10) $display("FAIL b2b_spacing: got %0d expected 10", second - first);
    else n_pass++;
    for (int i = 0; i < 12; i++) tick;
    n_checks++;
    if (lr1 !== 1'b1) $display("FAIL b2b_return_idle: got %b expected 1", lr1);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic exp_seq [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   bad = 0;
    data_in = 8'hC3; lv2 = 1'b1;
    tick;
    lv2 = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    n_checks++;
    if ({sel2, bv2, ent2} !== {3'd3, 1'b1, 8'hC3})
      $display("FAIL rstmid_4th_bit: got %b expected %b", {sel2, bv2, ent2}, {3'd3, 1'b1, 8'hC3});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lr2, sel2, ent2, bv2, busy2, done2} !== {1'b1, 3'd0, 8'd0, 3'b000})
      $display("FAIL rstmid_async: got %b expected %b",
               {lr2, sel2, ent2, bv2, busy2, done2}, {1'b1, 3'd0, 8'd0, 3'b000});
    else n_pass++;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done2 !== 1'b0 || busy2 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", bad);
    else n_pass++;
    data_in = 8'h5A; lv2 = 1'b1;
    tick;
    lv2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if ({sel2, bv2, ent2[sel2]} !== {3'(k / 2), 1'b1, exp_seq[k / 2]})
        $display("FAIL rstmid_reload cycle %0d: got %b expected %b", k,
                 {sel2, bv2, ent2[sel2]}, {3'(k / 2), 1'b1, exp_seq[k / 2]});
      else n_pass++;
      if (k < 15) tick;
    end
    tick;
    n_checks++;
    if ({done2, busy2} !== 2'b10) $display("FAIL rstmid_reload_done: got %b expected 10", {done2, busy2});
    else n_pass++;
    tick;
  endtask

`ifdef SERIALIZADOR_PAUSE_EN
  task automatic test_pause;
    logic exp_bit [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int   valid_cnt [0:7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int   bad = 0;
    data_in = 8'h3C; lv1 = 1'b1;
    tick;
    lv1 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if ({sel1, bv1, busy1} !== {3'd2, 2'b01})
          $display("FAIL pause_frozen cycle %0d: got %b expected %b", c, {sel1, bv1, busy1}, {3'd2, 2'b01});
        else n_pass++;
      end
      if (bv1 === 1'b1) begin
        valid_cnt[sel1]++;
        if (ent1[sel1] !== exp_bit[sel1]) bad++;
      end
      if (done1 !== 1'b0) bad++;
      pause = (c >= 3 && c <= 7);
      tick;
    end
    pause = 1'b0;
    n_checks++;
    if ({done1, busy1} !== 2'b10) $display("FAIL pause_done_time: got %b expected 10", {done1, busy1});
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL pause_bits: got %0d bad cycles expected 0", bad);
    else n_pass++;
    for (int s = 0; s < 8; s++) begin
      n_checks++;
      if (valid_cnt[s] !== 1) $display("FAIL pause_once sel %0d: got %0d expected 1", s, valid_cnt[s]);
      else n_pass++;
    end
    tick;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_div1_lsb;
    test_div3_msb;
    test_back_to_back;
    test_reset_mid;
`ifdef SERIALIZADOR_PAUSE_EN
    test_pause;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
